seg7_count_display: RTL and testbench
=====================================

# seg7_count_display

Downstream display stage for the debounced press counter. Takes the 8-bit LED count, converts it to three BCD digits with a sequential shift-add-3 (double-dabble) converter, and time-multiplexes the result onto a 4-digit common-anode seven-segment display. Conversions are started by a one-cycle load pulse. Conversion requests are buffered, so a value change during a conversion is never lost.

## Interface
- REFRESH_BITS, 18: width of the refresh counter; each digit is lit for 2^(REFRESH_BITS-2) clocks.
- Clk  input  1  system clock, all state on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Value  input  8  unsigned binary value to display (the count output)
- Load  input  1  one-cycle pulse: capture Value and request conversion
- Busy  output  1  high while a conversion is in progress or pending
- Anodes  output  4  digit enables, active-low; bit0 = rightmost (ones)
- Segments  output  7  {g,f,e,d,c,b,a}, active-low
- Dp  output  1  decimal point, active-low; constant 1 (off)

## Operation
- Capture register: Value is latched on any cycle with Load=1. A Load while Busy=1 overwrites the capture register and sets a pending flag; the last Load wins.
- Converter FSM states:
  - IDLE: Load -> CONVERT with iteration counter = 0.
  - CONVERT: runs exactly 8 iterations. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd[11:0], bin[7:0]} left by 1. After the 8th iteration -> COMMIT.
  - COMMIT: copies bcd[11:0] into the display register. If pending is set, clear it and go to CONVERT with the captured value; otherwise go to IDLE.
- Busy = (state != IDLE).
- Display register: hundreds/tens/ones nibbles. Hundreds is never > 2.
- Refresh counter: REFRESH_BITS wide, free-running, wraps. Digit index = counter[REFRESH_BITS-1 -: 2].
- Digit mapping:
  - Index 0 = ones, always shown.
  - Index 1 = tens, blanked if hundreds=0 and tens=0.
  - Index 2 = hundreds, blanked if 0.
  - Index 3 = always blank.
- Anodes = ~(4'b0001 << index). Blank digit drives Segments=7'b1111111.
- Digit patterns (active-low), 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
- Reset values:
  - Outputs: Busy=0, Anodes=4'b1110, Segments=7'b1000000 ("0"), Dp=1.
  - Internal: display register 0, refresh counter 0, pending 0, state IDLE, capture register 0.
- Load sampled at edge t: Busy=1 from t+1. CONVERT occupies t+1..t+8, COMMIT is t+9. Busy=0 from t+10 if nothing is pending.
- New digits are visible on the display from t+10, with whichever digit index is current.
- Load during COMMIT is treated as pending: conversion restarts at the next edge and Busy stays high continuously.
- Load in IDLE on the same cycle the refresh counter wraps: no interaction, the two are independent.
- Rst_n low mid-conversion: all state returns to reset values immediately (asynchronously). The partial result is discarded and is never committed.
- Outputs are registered-state decodes. Anodes and Segments change on the same edge; there is no inter-digit ghosting cycle.

## Structure
- Package seg7_pkg:
  - Converter state enum (IDLE, CONVERT, COMMIT).
  - SEG_BLANK constant.
  - 10-entry digit pattern constant array.
  - Digit index type (2 bits).
- Sub-module bin2bcd_seq: converter FSM, capture register, pending flag and Busy.
  - Ports: Clk, Rst_n, Value, Load, Busy, Bcd[11:0], BcdValid pulse on COMMIT.
- Top level: display register, refresh counter, blanking and segment decode.

## Test plan
- Reset with REFRESH_BITS=4 -> Anodes step 1110, 1101, 1011, 0111 every 4 clocks. Segments are 1000000 on index 0 and 1111111 elsewhere. Busy=0.
- Load Value=255 -> Busy high exactly 9 cycles. The display then shows hundreds 0100100 ("2"), tens 0010010 ("5"), ones 0010010 ("5").
- Load 7 -> only the ones digit is lit, showing 1111000. Then Load 100 -> hundreds "1" (1111001), tens "0" (1000000, not blanked), ones "0".
- Load 42, then Load 9 and Load 13 during cycles 3 and 5 of Busy:
  - "42" commits at cycle 9; Busy stays high.
  - "13" commits 9 cycles later (the 9 is never shown).
  - Busy then drops.
- Display 200 committed, then Load 37 and assert Rst_n at CONVERT iteration 4 -> Busy=0 immediately and the display shows "0". After release, Load 5 shows "5".
- Sweep all 256 values via Load -> each committed BCD matches a reference model, and blanking is correct for 0, 9, 10, 99 and 100.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, segment patterns and the double-dabble adjust step.
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} conv_state_t;
  typedef logic [1:0] digit_idx_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  function automatic logic [11:0] dabble_adj(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/seg7_count_display_if.sv
// seg7_count_display_if: value/load request bus with busy status back to the requester.
interface seg7_count_display_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  modport master (output value, load, input busy);
  modport slave  (input value, load, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 8-bit to 3-digit BCD converter with last-wins request buffering.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic [11:0] o_bcd,
  output logic        o_bcd_valid
);
  conv_state_t r_state, w_next;
  logic [7:0]  r_cap, r_bin, w_src;
  logic [11:0] r_bcd;
  logic [2:0]  r_iter;
  logic        r_pend, w_start;
  logic [19:0] w_shift;
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_src   = i_load ? i_value : r_cap;
    w_shift = {dabble_adj(r_bcd), r_bin} << 1;
    case (r_state)
      IDLE: begin
        w_start = i_load;
        w_next  = i_load ? CONVERT : IDLE;
      end
      CONVERT: w_next = (r_iter == 3'd7) ? COMMIT : CONVERT;
      COMMIT: begin
        // a load landing on the commit cycle restarts directly, same as a pending one
        w_start = i_load | r_pend;
        w_next  = (i_load | r_pend) ? CONVERT : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cap   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_iter  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (i_load) r_cap <= i_value;
      r_pend <= (r_state == CONVERT) & (r_pend | i_load);
      if (w_start) begin
        r_iter <= '0;
        r_bcd  <= '0;
        r_bin  <= w_src;
      end else if (r_state == CONVERT) begin
        r_iter         <= r_iter + 3'd1;
        {r_bcd, r_bin} <= w_shift;
      end
    end
  end
  always_comb begin
    o_busy      = (r_state != IDLE);
    o_bcd       = r_bcd;
    o_bcd_valid = (r_state == COMMIT);
  end
endmodule

// File: rtl/seg7_count_display.sv
// seg7_count_display: BCD-converts the press count and multiplexes it onto a 4-digit common-anode display.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  seg7_count_display_if.slave  bus,
  output logic [3:0]           o_anodes,
  output logic [6:0]           o_segments,
  output logic                 o_dp
);
  logic [11:0]             w_bcd, r_disp;
  logic                    w_bcd_valid, w_blank;
  logic [REFRESH_BITS-1:0] r_refresh;
  digit_idx_t              w_idx;
  logic [3:0]              w_nib;
  bin2bcd_seq u_conv (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_value     (bus.value),
    .i_load      (bus.load),
    .o_busy      (bus.busy),
    .o_bcd       (w_bcd),
    .o_bcd_valid (w_bcd_valid)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_disp    <= '0;
      r_refresh <= '0;
    end else begin
      r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      if (w_bcd_valid) r_disp <= w_bcd;
    end
  end
  // leading zeros are blanked; the leftmost digit position is never used
  always_comb begin
    w_idx      = r_refresh[REFRESH_BITS-1 -: 2];
    w_nib      = (w_idx == 2'd2) ? r_disp[11:8] : (w_idx == 2'd1) ? r_disp[7:4] : r_disp[3:0];
    w_blank    = (w_idx == 2'd3) | ((w_idx == 2'd2) & (r_disp[11:8] == 4'd0)) |
                 ((w_idx == 2'd1) & (r_disp[11:4] == 8'd0));
    o_anodes   = ~(4'b0001 << w_idx);
    o_segments = (w_blank || w_nib > 4'd9) ? SEG_BLANK : SEG_DIGITS[w_nib];
    o_dp       = 1'b1;
  end
endmodule

// File: tb/tb_seg7_count_display.sv
// tb_seg7_count_display: table, hand sequences and randomized loads against a timeline model.
module tb_seg7_count_display;
  localparam int RB = 4;
  localparam logic [6:0] BL = 7'b1111111;
  typedef struct { int v; logic [6:0] h, t, o; } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] anodes;
  logic [6:0] segs;
  logic dp;
  int checks = 0, errors = 0;
  logic [6:0] pat [10];
  int rc, bl, shown, cur, pend_val;
  bit pend;
  vec_t tbl [8];
  int order [256];
  seg7_count_display_if bus();
  seg7_count_display #(.REFRESH_BITS(RB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_anodes(anodes), .o_segments(segs), .o_dp(dp)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] exp_seg(int val, int idx);
    int h = val / 100, t = (val / 10) % 10, o = val % 10;
    case (idx)
      0: return pat[o];
      1: return (h == 0 && t == 0) ? BL : pat[t];
      2: return (h == 0) ? BL : pat[h];
      default: return BL;
    endcase
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    rc = 0; bl = 0; shown = 0; cur = 0; pend = 0; pend_val = 0;
  endtask
  // one clock: drive request, advance the timeline model, check outputs at the falling edge
  task automatic tick(input bit l, input int v);
    logic [3:0] ea;
    bus.load = l;
    bus.value = 8'(v);
    @(posedge clk);
    rc = (rc + 1) % (1 << RB);
    if (bl == 1) begin
      shown = cur;
      if (pend || l) begin cur = l ? v : pend_val; pend = 0; bl = 9; end
      else bl = 0;
    end else if (bl > 1) begin
      if (l) begin pend = 1; pend_val = v; end
      bl--;
    end else if (l) begin
      cur = v; bl = 9;
    end
    @(negedge clk);
    bus.load = 1'b0;
    ea = ~(4'b0001 << (rc / 4));
    chk("busy", 32'(bus.busy), 32'(bl > 0));
    chk("anodes", 32'(anodes), 32'(ea));
    chk("segments", 32'(segs), 32'(exp_seg(shown, rc / 4)));
    chk("dp", 32'(dp), 32'd1);
  endtask
  initial begin
    int cnt, idx, j, tmp;
    logic [6:0] e;
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    tbl = '{'{255, 7'b0100100, 7'b0010010, 7'b0010010},
            '{7,   BL,         BL,         7'b1111000},
            '{100, 7'b1111001, 7'b1000000, 7'b1000000},
            '{0,   BL,         BL,         7'b1000000},
            '{9,   BL,         BL,         7'b0010000},
            '{10,  BL,         7'b1111001, 7'b1000000},
            '{99,  BL,         7'b0010000, 7'b0010000},
            '{200, 7'b0100100, 7'b1000000, 7'b1000000}};
    bus.load = 1'b0;
    bus.value = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_anodes", 32'(anodes), 32'b1110);
    chk("rst_segs", 32'(segs), 32'b1000000);
    chk("rst_dp", 32'(dp), 32'd1);
    rst_n = 1'b1;
    repeat (16) tick(0, 0);
    foreach (tbl[i]) begin
      tick(1, tbl[i].v);
      cnt = int'(bus.busy);
      repeat (11) begin tick(0, 0); cnt += int'(bus.busy); end
      chk("busy_len", 32'(cnt), 32'd9);
      repeat (16) begin
        tick(0, 0);
        idx = rc / 4;
        e = (idx == 0) ? tbl[i].o : (idx == 1) ? tbl[i].t : (idx == 2) ? tbl[i].h : BL;
        chk("tbl_seg", 32'(segs), 32'(e));
      end
    end
    tick(1, 42);
    cnt = int'(bus.busy);
    tick(0, 0);  cnt += int'(bus.busy);
    tick(0, 0);  cnt += int'(bus.busy);
    tick(1, 9);  cnt += int'(bus.busy);
    tick(0, 0);  cnt += int'(bus.busy);
    tick(1, 13); cnt += int'(bus.busy);
    repeat (20) begin tick(0, 0); cnt += int'(bus.busy); end
    chk("pend_busy_len", 32'(cnt), 32'd18);
    tick(1, 200);
    repeat (12) tick(0, 0);
    tick(1, 37);
    repeat (4) tick(0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_anodes", 32'(anodes), 32'b1110);
    chk("midrst_segs", 32'(segs), 32'b1000000);
    @(negedge clk);
    chk("rsthold_segs", 32'(segs), 32'b1000000);
    rst_n = 1'b1;
    tick(1, 5);
    repeat (10) tick(0, 0);
    while (rc / 4 != 0) tick(0, 0);
    chk("after_rst_ones", 32'(segs), 32'b0010010);
    repeat (16) tick(0, 0);
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      tick(1, order[i]);
      repeat (16) tick(0, 0);
    end
    repeat (800) tick($urandom_range(0, 4) == 0, int'($urandom_range(0, 255)));
    repeat (20) tick(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
